auth_resp_serializer: RTL and testbench
=======================================

AUTH_RESP_SERIALIZER -- requirements
Module: auth_resp_serializer

Interface
REQ-001 SHALL have parameter MSG_BYTES, default `MSG_LEN/8 (32): number of bytes in a full response message.
REQ-002 SHALL have parameter ERR_BYTES, default 4: number of bytes in an error response message.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port Ack_in, input, 1 bit: response-ready level from the upstream challenge-answer stage.
REQ-006 SHALL have port Error_Invalid_Request_in, input, 1 bit: invalid-request level from the upstream stage.
REQ-007 SHALL have port header_in, input, `SIZE_OF_HEADER_VARS*`SIZE_OF_HEADER_IN_BYTES (32) bits: response header.
REQ-008 SHALL have port payload_in, input, `MSG_LEN-32 (224) bits: response payload.
REQ-009 SHALL have port tx_ready, input, 1 bit: downstream byte sink accepts the current byte.
REQ-010 SHALL have port tx_data, output, 8 bits: current byte.
REQ-011 SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-012 SHALL have port tx_last, output, 1 bit: tx_data is the final byte of the message.
REQ-013 SHALL have port busy, output, 1 bit: a message is being sent.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse after the final byte is accepted.

Function
REQ-015 SHALL register Ack_in and Error_Invalid_Request_in each cycle (ack_q, err_q) and detect rising edges as in=1 && q=0.
REQ-016 SHALL implement FSM states IDLE, SEND and DONE; reset state is IDLE.
REQ-017 IDLE, on an Ack rising edge only, SHALL load shreg[255:0] = {header_in, payload_in}, set len=MSG_BYTES and byte_cnt=0, then go to SEND.
REQ-018 IDLE, on an Error rising edge, SHALL load shreg[255:224] = {`PROTOCOL_VERSION, 8'h7F, 8'h01, 8'h00}, set the remaining bits to 0 and len=ERR_BYTES, then go to SEND.
REQ-019 When both edges occur in the same cycle, the Error load SHALL win.
REQ-020 In SEND, tx_valid SHALL be 1 and tx_data SHALL equal shreg[255:248] (most significant byte first, header byte 0 first).
REQ-021 tx_valid SHALL first assert in the cycle after the clk edge that sampled the rising edge (one-cycle latency).
REQ-022 On tx_valid && tx_ready, the block SHALL shift shreg left by 8 and increment byte_cnt (6 bits, range 0..32, no wrap).
REQ-023 While tx_valid && !tx_ready, tx_data, tx_last and shreg SHALL hold stable.
REQ-024 tx_last SHALL equal (state==SEND && byte_cnt==len-1).
REQ-025 An accepted byte with tx_last=1 SHALL move the FSM to DONE.
REQ-026 DONE SHALL assert done=1 and tx_valid=0 for exactly one cycle, then return to IDLE.
REQ-027 busy SHALL be 1 in SEND and DONE and 0 in IDLE.
REQ-028 Ack and Error edges in SEND or DONE SHALL be ignored and not queued.
REQ-029 A level still high on return to IDLE SHALL NOT retrigger; a new 0->1 transition is required.
REQ-030 tx_data SHALL be 8'h00 whenever tx_valid=0.

Reset
REQ-031 Asserting reset SHALL immediately force state=IDLE and tx_valid, tx_last, busy, done, tx_data, byte_cnt, shreg, len, ack_q and err_q to 0.
REQ-032 Reset asserted mid-message SHALL abort the message with no partial resumption; the first message after reset requires a fresh rising edge.

Structure
REQ-033 `MSG_LEN, `SIZE_OF_HEADER_VARS, `SIZE_OF_HEADER_IN_BYTES, `PROTOCOL_VERSION, the error code (`ERROR_CMD = 8'h7F) and the InvalidRequest code (`ERR_INVALID_REQUEST = 8'h01) SHALL come from the shared defines file.
REQ-034 The FSM state encodings SHALL be defined locally in the block.
REQ-035 The block SHALL be a single module with no sub-modules; the edge detector stays inline.

Verification
REQ-036 Scenario 1: Ack 0->1 with header 32'h10830001, tx_ready=1 -> 32 bytes, first 8'h10 then 8'h83; tx_last on byte 32; done pulses 1 cycle later.
REQ-037 Scenario 2: Error 0->1 -> bytes {PROTOCOL_VERSION, 7F, 01, 00}; tx_last on byte 4; busy high for 5 cycles.
REQ-038 Scenario 3: tx_ready toggled 1,0,0,1 during SEND -> tx_data holds across stalls; all 32 bytes arrive in order.
REQ-039 Scenario 4: Ack and Error rise in the same cycle -> 4-byte error message only.
REQ-040 Scenario 5: second Ack edge mid-SEND, with Ack held high after done -> no second message.
REQ-041 Scenario 6: reset asserted at byte 10 -> outputs 0 immediately; a new Ack edge after reset sends a full 32-byte message from byte 0.

Source files
------------

// File: rtl/auth_resp_serializer_pkg.sv
// Shared protocol defines plus derived widths for the auth response serializer.
`ifndef AUTH_RESP_DEFINES
`define AUTH_RESP_DEFINES
`define MSG_LEN                 256
`define SIZE_OF_HEADER_VARS     4
`define SIZE_OF_HEADER_IN_BYTES 8
`define PROTOCOL_VERSION        8'h10
`define ERROR_CMD               8'h7F
`define ERR_INVALID_REQUEST     8'h01
`endif

package auth_resp_serializer_pkg;
    localparam int HDR_W   = `SIZE_OF_HEADER_VARS * `SIZE_OF_HEADER_IN_BYTES;
    localparam int PAY_W   = `MSG_LEN - 32;
    localparam int SHREG_W = `MSG_LEN;

    // Header of the canned InvalidRequest error response.
    function automatic logic [31:0] err_header();
        return {`PROTOCOL_VERSION, `ERROR_CMD, `ERR_INVALID_REQUEST, 8'h00};
    endfunction
endpackage

// File: rtl/auth_resp_serializer.sv
// Serializes an auth response (full message or InvalidRequest error) into a
// valid/ready byte stream, MSB first, on a rising edge of Ack or Error.
module auth_resp_serializer
    import auth_resp_serializer_pkg::*;
#(
    parameter int MSG_BYTES = `MSG_LEN / 8,
    parameter int ERR_BYTES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Ack_in,
    input  logic             Error_Invalid_Request_in,
    input  logic [HDR_W-1:0] header_in,
    input  logic [PAY_W-1:0] payload_in,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    output logic             tx_last,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [SHREG_W-1:0] shreg;
    logic [5:0]         len;
    logic [5:0]         byte_cnt;
    logic               ack_q, err_q;
    logic               ack_rise, err_rise;
    logic               accept;

    assign ack_rise = Ack_in & ~ack_q;
    assign err_rise = Error_Invalid_Request_in & ~err_q;

    assign tx_valid = (state == SEND);
    assign tx_last  = (state == SEND) && (byte_cnt == len - 6'd1);
    assign tx_data  = tx_valid ? shreg[SHREG_W-1 -: 8] : 8'h00;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign accept   = tx_valid & tx_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: only IDLE reacts to edges, so edges while busy are dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (err_rise || ack_rise) state_nxt = SEND;
            SEND:    if (accept && tx_last)    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Edge-detect history, message load and byte shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            shreg    <= '0;
            len      <= '0;
            byte_cnt <= '0;
        end else begin
            ack_q <= Ack_in;
            err_q <= Error_Invalid_Request_in;
            if (state == IDLE) begin
                // Error outranks Ack when both rise together.
                if (err_rise) begin
                    shreg    <= {err_header(), {PAY_W{1'b0}}};
                    len      <= 6'(ERR_BYTES);
                    byte_cnt <= '0;
                end else if (ack_rise) begin
                    shreg    <= {header_in, payload_in};
                    len      <= 6'(MSG_BYTES);
                    byte_cnt <= '0;
                end
            end else if (accept) begin
                shreg <= shreg << 8;
                if (byte_cnt != 6'd32) byte_cnt <= byte_cnt + 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_auth_resp_serializer.sv
// Bench for auth_resp_serializer: directed scenarios plus random traffic,
// checked every cycle against a message-level reference model.
module tb_auth_resp_serializer;
    logic         clk = 1'b0;
    logic         reset;
    logic         Ack_in;
    logic         Error_Invalid_Request_in;
    logic [31:0]  header_in;
    logic [223:0] payload_in;
    logic         tx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid, tx_last, busy, done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    auth_resp_serializer dut (
        .clk(clk), .reset(reset), .Ack_in(Ack_in),
        .Error_Invalid_Request_in(Error_Invalid_Request_in),
        .header_in(header_in), .payload_in(payload_in), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .busy(busy), .done(done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = quiet, 1 = streaming m_msg, 2 = done pulse.
    int         m_mode = 0;
    int         m_pos  = 0;
    bit         m_pa = 0, m_pe = 0, m_ra, m_re;
    logic [7:0] m_msg[$];
    logic [255:0] m_full;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_pos = 0; m_pa = 0; m_pe = 0;
            m_msg.delete();
        end else begin
            m_ra = Ack_in && !m_pa;
            m_re = Error_Invalid_Request_in && !m_pe;
            m_pa = Ack_in;
            m_pe = Error_Invalid_Request_in;
            case (m_mode)
                0: begin
                    if (m_re) begin
                        m_msg = '{8'h10, 8'h7F, 8'h01, 8'h00};
                        m_pos = 0; m_mode = 1;
                    end else if (m_ra) begin
                        m_full = {header_in, payload_in};
                        m_msg.delete();
                        for (int i = 0; i < 32; i++) m_msg.push_back(m_full[255-8*i -: 8]);
                        m_pos = 0; m_mode = 1;
                    end
                end
                1: if (tx_ready) begin
                    m_pos++;
                    if (m_pos == m_msg.size()) m_mode = 2;
                end
                default: m_mode = 0;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [7:0] ed;
        ed = (m_mode == 1 && m_pos < m_msg.size()) ? m_msg[m_pos] : 8'h00;
        chk("tx_valid", 64'(tx_valid), 64'(m_mode == 1));
        chk("tx_data",  64'(tx_data),  64'(ed));
        chk("tx_last",  64'(tx_last),  64'(m_mode == 1 && m_pos == m_msg.size() - 1));
        chk("busy",     64'(busy),     64'(m_mode != 0));
        chk("done",     64'(done),     64'(m_mode == 2));
    end

    logic [7:0] got[64];

    // Runs until done (bounded); pattern 0 = always ready, 1 = ready 1,0,0,1.
    task automatic run_msg(input int pat, output int nb, output int bc,
                           output int last_idx, output int gap);
        int c_last, k;
        bit ok;
        nb = 0; bc = 0; last_idx = -1; gap = -1; c_last = 0; k = 0; ok = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin gap = c - c_last; ok = 1; break; end
            tx_ready = (pat == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            k++;
            if (tx_valid && tx_ready) begin
                got[nb] = tx_data;
                if (tx_last) begin last_idx = nb; c_last = c; end
                nb++;
            end
        end
        if (!ok) chk("run_msg_timeout", 64'd0, 64'd1);
        tx_ready = 1'b1;
    endtask

    task automatic raise(input bit a, input bit e);
        @(negedge clk);
        Ack_in = a;
        Error_Invalid_Request_in = e;
    endtask

    logic [255:0] vec;
    int nb, bc, li, gap, seen;

    initial begin
        reset = 1'b1; Ack_in = 0; Error_Invalid_Request_in = 0;
        header_in = '0; payload_in = '0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_data", 64'(tx_data), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Scenario 1: full message, always ready.
        header_in = 32'h10830001;
        payload_in = {7{$urandom()}};
        vec = {header_in, payload_in};
        raise(1, 0);
        run_msg(0, nb, bc, li, gap);
        Ack_in = 0;
        chk("s1_bytes", 64'(nb), 64'd32);
        chk("s1_b0", 64'(got[0]), 64'h10);
        chk("s1_b1", 64'(got[1]), 64'h83);
        chk("s1_last_idx", 64'(li), 64'd31);
        chk("s1_done_gap", 64'(gap), 64'd1);
        chk("s1_busy_cycles", 64'(bc), 64'd33);

        // Scenario 2: error message.
        raise(0, 1);
        run_msg(0, nb, bc, li, gap);
        Error_Invalid_Request_in = 0;
        chk("s2_bytes", 64'(nb), 64'd4);
        chk("s2_msg", 64'({got[0], got[1], got[2], got[3]}), 64'h107F0100);
        chk("s2_last_idx", 64'(li), 64'd3);
        chk("s2_busy_cycles", 64'(bc), 64'd5);

        // Scenario 3: stalls, bytes in order.
        header_in = $urandom(); payload_in = {7{$urandom()}};
        vec = {header_in, payload_in};
        raise(1, 0);
        run_msg(1, nb, bc, li, gap);
        Ack_in = 0;
        chk("s3_bytes", 64'(nb), 64'd32);
        for (int i = 0; i < 32; i++) chk("s3_order", 64'(got[i]), 64'(vec[255-8*i -: 8]));

        // Scenario 4: simultaneous edges, error wins.
        raise(1, 1);
        run_msg(0, nb, bc, li, gap);
        chk("s4_bytes", 64'(nb), 64'd4);
        chk("s4_b1", 64'(got[1]), 64'h7F);
        Ack_in = 0; Error_Invalid_Request_in = 0;

        // Scenario 5: second Ack edge mid-send, Ack held after done.
        raise(1, 0);
        repeat (5) @(negedge clk);
        Ack_in = 0;
        @(negedge clk);
        Ack_in = 1;
        run_msg(0, nb, bc, li, gap);
        chk("s5_rest_bytes", 64'(nb), 64'd26);
        seen = 0;
        repeat (10) begin @(negedge clk); if (busy || tx_valid) seen++; end
        chk("s5_no_retrigger", 64'(seen), 64'd0);
        Ack_in = 0;

        // Scenario 6: reset at byte 10, then a fresh full message.
        header_in = $urandom(); payload_in = {7{$urandom()}};
        vec = {header_in, payload_in};
        raise(1, 0);
        @(negedge clk);
        Ack_in = 0;
        repeat (10) @(negedge clk);
        chk("s6_byte10", 64'(tx_data), 64'(vec[255-80 -: 8]));
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("s6_rst_out", 64'({tx_valid, tx_last, busy, done, tx_data}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        header_in = 32'hA5C3_0F1E;
        vec = {header_in, payload_in};
        raise(1, 0);
        run_msg(0, nb, bc, li, gap);
        Ack_in = 0;
        chk("s6_bytes", 64'(nb), 64'd32);
        chk("s6_b0", 64'(got[0]), 64'hA5);

        // Random traffic, checked by the per-cycle compare.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            tx_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) Ack_in = ~Ack_in;
            if ($urandom_range(0, 39) == 0) Error_Invalid_Request_in = ~Error_Invalid_Request_in;
            if (!Ack_in) begin
                header_in = $urandom();
                payload_in = {$urandom(), $urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom()};
            end
            if (c == 2500) begin #2 reset = 1'b1; #3 reset = 1'b0; end
        end
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
